// File: rtl/tech_sync_debounce_pkg.sv
// Shared constants for the debounce block: FSM encoding and glitch counter width.
package tech_sync_debounce_pkg;
  typedef enum logic {
    STABLE  = 1'b0,
    QUALIFY = 1'b1
  } deb_state_e;

  localparam int GLITCH_W = 8;
endpackage

// File: rtl/tech_sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over increment.
// When clear and increment arrive together, the count restarts at 1.
module tech_sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (en) begin
      if (clr)
        count <= inc ? WIDTH'(1) : '0;
      else if (inc && (count != '1))
        count <= count + WIDTH'(1);
    end
  end
endmodule

// File: rtl/tech_sync_debounce.sv
// Debounces a synchronised level: q only follows d after N consecutive enabled cycles of d!=q.
// Emits registered rise/fall strobes and counts rejected transitions.
module tech_sync_debounce
  import tech_sync_debounce_pkg::*;
#(
  parameter int CNT_WIDTH   = 16,
  parameter bit RESET_LEVEL = 1'b0
) (
  input  logic                 clk,
  input  logic                 clk__enable,
  input  logic                 reset,
  input  logic                 d,
  input  logic [CNT_WIDTH-1:0] threshold,
  input  logic                 glitch_clear,
  output logic                 q,
  output logic                 rise,
  output logic                 fall,
  output logic                 busy,
  output logic [GLITCH_W-1:0]  glitch_count
);
  deb_state_e           state, state_nxt;
  logic [CNT_WIDTH-1:0] cnt, n_eff;
  logic [CNT_WIDTH:0]   cnt_plus;
  logic                 commit, cnt_inc, cnt_clr, glitch;

  always_comb begin
    n_eff     = (threshold == '0) ? CNT_WIDTH'(1) : threshold;
    cnt_plus  = {1'b0, cnt} + {{CNT_WIDTH{1'b0}}, 1'b1};
    state_nxt = state;
    commit    = 1'b0;
    cnt_clr   = 1'b1;
    cnt_inc   = 1'b0;
    glitch    = 1'b0;
    case (state)
      STABLE: begin
        if (d != q) begin
          if (n_eff == CNT_WIDTH'(1))
            commit = 1'b1;
          else begin
            // clr+inc restarts the qualify count at 1
            state_nxt = QUALIFY;
            cnt_inc   = 1'b1;
          end
        end
      end
      QUALIFY: begin
        if (d == q) begin
          state_nxt = STABLE;
          glitch    = 1'b1;
        end else if (cnt_plus >= {1'b0, n_eff}) begin
          state_nxt = STABLE;
          commit    = 1'b1;
        end else begin
          cnt_clr = 1'b0;
          cnt_inc = 1'b1;
        end
      end
      default: state_nxt = STABLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= STABLE;
      q     <= RESET_LEVEL;
      rise  <= 1'b0;
      fall  <= 1'b0;
      busy  <= 1'b0;
    end else if (clk__enable) begin
      state <= state_nxt;
      busy  <= (state_nxt == QUALIFY);
      rise  <= commit & d;
      fall  <= commit & ~d;
      if (commit)
        q <= d;
    end
  end

  tech_sat_counter #(.WIDTH(CNT_WIDTH)) u_qual_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (clk__enable),
    .inc   (cnt_inc),
    .clr   (cnt_clr),
    .count (cnt)
  );

  tech_sat_counter #(.WIDTH(GLITCH_W)) u_glitch_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (clk__enable),
    .inc   (glitch),
    .clr   (glitch_clear),
    .count (glitch_count)
  );
endmodule
